// File: rtl/div_seq_pkg.sv
// Shared types and constant fill patterns for the divider request sequencer.
package div_seq_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} div_seq_state_t;

   // Bit patterns replicated to the operand width for locally generated responses
   localparam logic DIV_ZERO_Q_FILL   = 1'b1;
   localparam logic TIMEOUT_DATA_FILL = 1'b0;

endpackage

// File: rtl/div_request_sequencer_rise_detect.sv
// 1-bit edge detector: registers the input and flags a low-to-high transition.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic rise
);

   logic res_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= 1'b0;
      end else begin
         res_q <= in;
      end
   end

   assign rise = in & ~res_q;

endmodule

// File: rtl/div_request_sequencer.sv
// Valid/ready front-end for DivisorUnit: one divide in flight, timeout-protected.
// Optional feature macro DIV_ZERO_BYPASS_EN answers divide-by-zero requests locally.
module div_request_sequencer
   import div_seq_pkg::*;
#(
   parameter int parallelism    = 32,
   parameter int TIMEOUT_CYCLES = 128
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_usigned,
   input  logic [parallelism-1:0] req_dividend,
   input  logic [parallelism-1:0] req_divisor,
   output logic                   div_valid,
   output logic                   div_usigned,
   output logic [parallelism-1:0] div_dividend,
   output logic [parallelism-1:0] div_divisor,
   input  logic                   div_res_ready,
   input  logic [parallelism-1:0] div_quotient,
   input  logic [parallelism-1:0] div_reminder,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [parallelism-1:0] rsp_quotient,
   output logic [parallelism-1:0] rsp_reminder,
   output logic                   rsp_error,
   output logic                   busy
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   div_seq_state_t state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic req_ready_reg, req_ready_next;
   logic busy_reg, busy_next;
   logic div_valid_reg, div_valid_next;
   logic div_usigned_reg, div_usigned_next;
   logic [parallelism-1:0] div_dividend_reg, div_dividend_next;
   logic [parallelism-1:0] div_divisor_reg, div_divisor_next;
   logic rsp_valid_reg, rsp_valid_next;
   logic [parallelism-1:0] rsp_quotient_reg, rsp_quotient_next;
   logic [parallelism-1:0] rsp_reminder_reg, rsp_reminder_next;
   logic rsp_error_reg, rsp_error_next;
   logic res_rise, accept, timeout_hit, bypass;

   rise_detect u_rise_detect (
      .clk  (clk),
      .rst_n(rst_n),
      .in   (div_res_ready),
      .rise (res_rise)
   );

`ifdef DIV_ZERO_BYPASS_EN
   assign bypass = (req_divisor == '0);
`else
   assign bypass = 1'b0;
`endif

   assign accept      = (state_reg == IDLE) & req_valid & req_ready_reg;
   assign timeout_hit = (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         cnt_reg          <= '0;
         req_ready_reg    <= 1'b0;
         busy_reg         <= 1'b0;
         div_valid_reg    <= 1'b0;
         div_usigned_reg  <= 1'b0;
         div_dividend_reg <= '0;
         div_divisor_reg  <= '0;
         rsp_valid_reg    <= 1'b0;
         rsp_quotient_reg <= '0;
         rsp_reminder_reg <= '0;
         rsp_error_reg    <= 1'b0;
      end else begin
         state_reg        <= state_next;
         cnt_reg          <= cnt_next;
         req_ready_reg    <= req_ready_next;
         busy_reg         <= busy_next;
         div_valid_reg    <= div_valid_next;
         div_usigned_reg  <= div_usigned_next;
         div_dividend_reg <= div_dividend_next;
         div_divisor_reg  <= div_divisor_next;
         rsp_valid_reg    <= rsp_valid_next;
         rsp_quotient_reg <= rsp_quotient_next;
         rsp_reminder_reg <= rsp_reminder_next;
         rsp_error_reg    <= rsp_error_next;
      end
   end

   // A rise beats a timeout that lands on the same cycle
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = bypass ? RESP : ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (res_rise || timeout_hit) state_next = RESP;
         RESP:    if (rsp_valid_reg && rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Every output is registered, so flags are derived from the upcoming state
   always_comb begin
      req_ready_next    = (state_next == IDLE);
      busy_next         = (state_next != IDLE);
      div_valid_next    = (state_next == ISSUE);
      rsp_valid_next    = (state_next == RESP);
      cnt_next          = cnt_reg;
      div_usigned_next  = div_usigned_reg;
      div_dividend_next = div_dividend_reg;
      div_divisor_next  = div_divisor_reg;
      rsp_quotient_next = rsp_quotient_reg;
      rsp_reminder_next = rsp_reminder_reg;
      rsp_error_next    = rsp_error_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (bypass) begin
                  rsp_quotient_next = {parallelism{DIV_ZERO_Q_FILL}};
                  rsp_reminder_next = req_dividend;
                  rsp_error_next    = 1'b0;
               end else begin
                  div_usigned_next  = req_usigned;
                  div_dividend_next = req_dividend;
                  div_divisor_next  = req_divisor;
               end
            end
         end
         ISSUE: cnt_next = '0;
         WAIT: begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (res_rise) begin
               rsp_quotient_next = div_quotient;
               rsp_reminder_next = div_reminder;
               rsp_error_next    = 1'b0;
            end else if (timeout_hit) begin
               rsp_quotient_next = {parallelism{TIMEOUT_DATA_FILL}};
               rsp_reminder_next = {parallelism{TIMEOUT_DATA_FILL}};
               rsp_error_next    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign req_ready    = req_ready_reg;
   assign busy         = busy_reg;
   assign div_valid    = div_valid_reg;
   assign div_usigned  = div_usigned_reg;
   assign div_dividend = div_dividend_reg;
   assign div_divisor  = div_divisor_reg;
   assign rsp_valid    = rsp_valid_reg;
   assign rsp_quotient = rsp_quotient_reg;
   assign rsp_reminder = rsp_reminder_reg;
   assign rsp_error    = rsp_error_reg;

endmodule

// File: tb/tb_div_request_sequencer.sv
// Self-checking bench: transaction-level model, stand-in divider, directed and random traffic.
module tb_div_request_sequencer;

   localparam int W   = 32;
   localparam int TMO = 128;
`ifdef DIV_ZERO_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_valid = 1'b0, req_usigned = 1'b0;
   logic [W-1:0] req_dividend = '0, req_divisor = '0;
   logic req_ready, div_valid, div_usigned, div_res_ready;
   logic [W-1:0] div_dividend, div_divisor;
   logic [W-1:0] div_quotient = '0, div_reminder = '0;
   logic rsp_valid, rsp_error, busy;
   logic rsp_ready = 1'b0;
   logic [W-1:0] rsp_quotient, rsp_reminder;

   int checks = 0, errors = 0, cyc = 0, dv_count = 0;
   int div_lat = 3;
   logic div_stuck = 1'b0, res_lvl = 1'b0;

   div_request_sequencer #(.parallelism(W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_usigned(req_usigned),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .div_valid(div_valid), .div_usigned(div_usigned),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_res_ready(div_res_ready), .div_quotient(div_quotient), .div_reminder(div_reminder),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_quotient(rsp_quotient), .rsp_reminder(rsp_reminder),
      .rsp_error(rsp_error), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   assign div_res_ready = div_stuck | res_lvl;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   // Arithmetic reference: truncating signed division, RISC-V style x/0 and overflow
   function automatic void ref_div(input logic us, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
      if (b == '0) begin
         q = '1; r = a;
      end else if (us) begin
         q = a / b; r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a; r = '0;
      end else begin
         q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end
   endfunction

   // Stand-in divider: drops res_ready on start, raises it div_lat cycles later
   initial begin
      int dcnt;
      logic [W-1:0] qp, rp;
      dcnt = 0; qp = '0; rp = '0;
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            res_lvl = 1'b0; dcnt = 0;
         end else if (div_valid) begin
            res_lvl = 1'b0; dcnt = div_lat;
            ref_div(div_usigned, div_dividend, div_divisor, qp, rp);
            div_quotient = $urandom; div_reminder = $urandom;
         end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
               res_lvl = 1'b1; div_quotient = qp; div_reminder = rp;
            end
         end
      end
   end

   // Behavioural model: what each output must show after every clock edge
   logic e_req_ready, e_busy, e_div_valid, e_div_us, e_rsp_valid, e_rsp_err;
   logic [W-1:0] e_div_a, e_div_b, e_rsp_q, e_rsp_r;
   bit m_busy, m_wait, m_resp, prev_res;
   int m_t_acc;

   task automatic model_reset();
      m_busy = 0; m_wait = 0; m_resp = 0; prev_res = 0; m_t_acc = 0;
      e_req_ready = 0; e_busy = 0; e_div_valid = 0; e_div_us = 0; e_rsp_valid = 0; e_rsp_err = 0;
      e_div_a = '0; e_div_b = '0; e_rsp_q = '0; e_rsp_r = '0;
   endtask

   task automatic model_step();
      bit rise;
      cyc++;
      rise = div_res_ready && !prev_res;
      prev_res = div_res_ready;
      e_div_valid = 0;
      if (!m_busy) begin
         if (req_valid && e_req_ready) begin
            m_busy = 1;
            if (BYPASS && req_divisor == '0) begin
               m_resp = 1; e_rsp_q = '1; e_rsp_r = req_dividend; e_rsp_err = 0;
            end else begin
               m_wait = 1; m_t_acc = cyc; e_div_valid = 1;
               e_div_us = req_usigned; e_div_a = req_dividend; e_div_b = req_divisor;
            end
         end
      end else if (m_wait) begin
         if (cyc >= m_t_acc + 2 && rise) begin
            m_wait = 0; m_resp = 1; e_rsp_q = div_quotient; e_rsp_r = div_reminder; e_rsp_err = 0;
         end else if (cyc == m_t_acc + 1 + TMO) begin
            m_wait = 0; m_resp = 1; e_rsp_q = '0; e_rsp_r = '0; e_rsp_err = 1;
         end
      end else if (m_resp && rsp_ready) begin
         m_resp = 0; m_busy = 0;
      end
      e_req_ready = !m_busy;
      e_busy = m_busy;
      e_rsp_valid = m_resp;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // Compare process: every output against the model on every falling edge
   initial forever begin
      @(negedge clk);
      if (div_valid === 1'b1) dv_count++;
      chk1("req_ready", req_ready, e_req_ready);
      chk1("busy", busy, e_busy);
      chk1("div_valid", div_valid, e_div_valid);
      chk1("div_usigned", div_usigned, e_div_us);
      chk("div_dividend", div_dividend, e_div_a);
      chk("div_divisor", div_divisor, e_div_b);
      chk1("rsp_valid", rsp_valid, e_rsp_valid);
      chk("rsp_quotient", rsp_quotient, e_rsp_q);
      chk("rsp_reminder", rsp_reminder, e_rsp_r);
      chk1("rsp_error", rsp_error, e_rsp_err);
   end

   task automatic send(input logic us, input logic [W-1:0] a, input logic [W-1:0] b, output int t_acc);
      int n;
      n = 0;
      req_usigned = us; req_dividend = a; req_divisor = b; req_valid = 1'b1;
      while (req_ready !== 1'b1 && n < 400) begin
         @(negedge clk); n++;
      end
      chk1("accept_bound", n < 400, 1'b1);
      t_acc = cyc + 1;
      @(negedge clk);
      req_valid = 1'b0; req_usigned = 1'($urandom); req_dividend = $urandom; req_divisor = $urandom;
   endtask

   task automatic wait_rsp(input int hold, output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic e, output int t_rsp, output int t_hs);
      int n;
      n = 0;
      rsp_ready = 1'b0;
      while (rsp_valid !== 1'b1 && n < 400) begin
         @(negedge clk); n++;
      end
      chk1("rsp_bound", n < 400, 1'b1);
      t_rsp = cyc; q = rsp_quotient; r = rsp_reminder; e = rsp_error;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_quotient", rsp_quotient, q);
         chk("hold_reminder", rsp_reminder, r);
         chk1("hold_req_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1; t_hs = cyc + 1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic txn(input logic us, input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                      output logic [W-1:0] q, output logic [W-1:0] r, output logic e,
                      output int t_acc, output int t_rsp, output int t_hs);
      send(us, a, b, t_acc);
      wait_rsp(hold, q, r, e, t_rsp, t_hs);
      $display("txn us=%0d a=%h b=%h -> q=%h r=%h err=%0d lat=%0d", us, a, b, q, r, e, t_rsp - t_acc);
   endtask

   initial begin
      logic [W-1:0] q, r, xq, xr;
      logic e;
      int ta, tr, th, ta2, dv0;

      repeat (3) @(negedge clk);
      chk1("reset_req_ready", req_ready, 1'b0);
      chk1("reset_busy", busy, 1'b0);
      rst_n = 1'b1;
      chk1("pre_edge_req_ready", req_ready, 1'b0);
      @(negedge clk);
      chk1("first_edge_req_ready", req_ready, 1'b1);

      // unsigned 100 / 7
      div_lat = 4; dv0 = dv_count;
      txn(1'b1, 32'd100, 32'd7, 0, q, r, e, ta, tr, th);
      chk("u100_7_q", q, 32'd14); chk("u100_7_r", r, 32'd2); chk1("u100_7_err", e, 1'b0);
      chk("u100_7_div_valid_cycles", dv_count - dv0, 32'd1);

      // signed -100 / 7 with consumer stalling for 5 cycles
      div_lat = 6;
      txn(1'b0, 32'hFFFF_FF9C, 32'd7, 5, q, r, e, ta, tr, th);
      chk("s100_7_q", q, 32'hFFFF_FFF2); chk("s100_7_r", r, 32'hFFFF_FFFE);

      // res_ready stuck high across issue: only the timeout can end the wait
      div_stuck = 1'b1; div_lat = 3;
      txn(1'b1, 32'd55, 32'd5, 0, q, r, e, ta, tr, th);
      div_stuck = 1'b0;
      chk1("stuck_err", e, 1'b1); chk("stuck_q", q, 32'd0); chk("stuck_r", r, 32'd0);
      chk("stuck_latency", tr - ta, 32'd129);

      // divide by zero
      dv0 = dv_count; div_lat = 2;
      txn(1'b0, 32'h1234_5678, 32'd0, 1, q, r, e, ta, tr, th);
      chk("dz_q", q, 32'hFFFF_FFFF); chk("dz_r", r, 32'h1234_5678); chk1("dz_err", e, 1'b0);
      chk("dz_div_valid_cycles", dv_count - dv0, BYPASS ? 32'd0 : 32'd1);

      // reset asserted while waiting on the divider
      div_lat = 20;
      send(1'b1, 32'd50, 32'd5, ta);
      repeat (5) @(negedge clk);
      chk1("pre_reset_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("rst_busy", busy, 1'b0); chk1("rst_req_ready", req_ready, 1'b0);
      chk1("rst_div_valid", div_valid, 1'b0); chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_div_dividend", div_dividend, 32'd0); chk("rst_rsp_quotient", rsp_quotient, 32'd0);
      chk("rst_rsp_reminder", rsp_reminder, 32'd0); chk1("rst_rsp_error", rsp_error, 1'b0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      div_lat = 3;
      txn(1'b1, 32'd81, 32'd9, 0, q, r, e, ta, tr, th);
      chk("r81_9_q", q, 32'd9); chk("r81_9_r", r, 32'd0);

      // back-to-back: next accept exactly one cycle after the response handshake
      txn(1'b1, 32'd1000, 32'd10, 0, q, r, e, ta, tr, th);
      send(1'b1, 32'd999, 32'd3, ta2);
      chk("b2b_gap", ta2 - th, 32'd1);
      wait_rsp(0, q, r, e, tr, th);
      chk("b2b_q", q, 32'd333);

      // randomized traffic checked against plain arithmetic
      for (int k = 0; k < 40; k++) begin
         logic us;
         logic [W-1:0] a, b;
         us = 1'($urandom); a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = 32'hFFFF_FFFF;
            2, 3:    b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         div_lat = $urandom_range(1, 12);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         txn(us, a, b, $urandom_range(0, 3), q, r, e, ta, tr, th);
         ref_div(us, a, b, xq, xr);
         chk("rand_q", q, xq); chk("rand_r", r, xr); chk1("rand_err", e, 1'b0);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "time limit");
   end

endmodule
